// File: rtl/gate_stim_sequencer_if.sv
// Control/stimulus bundle for gate_stim_sequencer.
//   master : supervising controller (drives start/pause/abort, observes the rest)
//   slave  : the sequencer itself
// Signals:
//   start, pause, abort   controller -> sequencer
//   aa, bb, cc            registered gate inputs
//   step_idx[2:0]         pattern step currently driven
//   step_strobe           first cycle of each step
//   busy, done            RUN/HOLD indicator, end-of-sequence pulse
interface gate_stim_sequencer_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic       aa;
  logic       bb;
  logic       cc;
  logic [2:0] step_idx;
  logic       step_strobe;
  logic       busy;
  logic       done;

  modport master (
    output start, pause, abort,
    input  aa, bb, cc, step_idx, step_strobe, busy, done
  );

  modport slave (
    input  start, pause, abort,
    output aa, bb, cc, step_idx, step_strobe, busy, done
  );
endinterface

// File: rtl/gate_stim_sequencer.sv
// Stimulus generator for the and_or_not_xor gate block.
// Walks a fixed 7-step {aa,bb,cc} pattern, holding each step DWELL_CYCLES
// cycles, holds the last step HOLD_CYCLES more, then pulses done.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of gate_stim_sequencer_if (start/pause/abort in;
//          aa/bb/cc, step_idx, step_strobe, busy, done out, all from flops)
module gate_stim_sequencer #(
  parameter int DWELL_CYCLES = 10,
  parameter int HOLD_CYCLES  = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_stim_sequencer_if.slave  bus
);

  localparam int MAXV = (DWELL_CYCLES > HOLD_CYCLES) ? DWELL_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] DWELL_RL = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_RL  = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST     = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    abc_q, abc_d;   // {aa,bb,cc}
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [2:0] pat(input logic [2:0] i);
    case (i)
      3'd0:    pat = 3'b000;
      3'd1:    pat = 3'b100;
      3'd2:    pat = 3'b000;
      3'd3:    pat = 3'b010;
      3'd4:    pat = 3'b110;
      3'd5:    pat = 3'b111;
      default: pat = 3'b110;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    abc_d    = abc_q;
    strobe_d = 1'b0;

    if (bus.abort && state_q != IDLE) begin
      // abort is a no-op in IDLE so a coincident start still launches
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      abc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d  = RUN;
            cnt_d    = DWELL_RL;
            idx_d    = '0;
            abc_d    = pat(3'd0);
            strobe_d = 1'b1;
          end
        end
        RUN: begin
          if (!bus.pause) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (idx_q != LAST) begin
              idx_d    = idx_q + 3'd1;
              abc_d    = pat(idx_q + 3'd1);
              cnt_d    = DWELL_RL;
              strobe_d = 1'b1;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_RL;
            end
          end
        end
        HOLD: begin
          if (!bus.pause) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             state_d = DONE;
          end
        end
        default: begin   // DONE: single cycle, outputs still on last step
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          abc_d   = '0;
        end
      endcase
    end

    // status flags registered alongside the state they describe
    busy_d = (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      abc_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      abc_q    <= abc_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.aa          = abc_q[2];
  assign bus.bb          = abc_q[1];
  assign bus.cc          = abc_q[0];
  assign bus.step_idx    = idx_q;
  assign bus.step_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_gate_stim_sequencer.sv
module tb_gate_stim_sequencer;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   t;   // cycles since the launching edge E0

  gate_stim_sequencer_if bus ();

  gate_stim_sequencer #(.DWELL_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {aa,bb,cc} for steps 0..6
  logic [2:0] exp_pat [7] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b110, 3'b111, 3'b110};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic launch();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t = 0;
    bus.start = 1'b0;
  endtask

  task automatic to_cycle(input int target);
    while (t < target) tick();
  endtask

  task automatic chk_all(input string tag, input logic [2:0] abc, input logic [2:0] idx,
                         input logic strobe, input logic busy, input logic done);
    chk({tag, ".abc"},    {bus.aa, bus.bb, bus.cc}, abc);
    chk({tag, ".idx"},    bus.step_idx, idx);
    chk({tag, ".strobe"}, bus.step_strobe, strobe);
    chk({tag, ".busy"},   bus.busy, busy);
    chk({tag, ".done"},   bus.done, done);
  endtask

  // full undisturbed run, checked every cycle from E0 to E0+37
  task automatic full_run(input string tag);
    int s;
    launch();
    for (int k = 0; k <= 37; k++) begin
      if (k > 0) tick();
      s = (k < 28) ? k / 4 : 6;
      if (k == 37) chk_all(tag, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
      else chk_all(tag, exp_pat[s], 3'(s), (k < 28) && (k % 4 == 0), k < 36, k == 36);
    end
  endtask

  initial begin
    t = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk_all("reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

    // full sequence
    full_run("full");
    tick();

    // pause for 5 cycles starting at E0+6
    launch();
    to_cycle(5);
    bus.pause = 1'b1;
    to_cycle(10);
    bus.pause = 1'b0;
    chk("pause.frozen_strobe", bus.step_strobe, 1'b0);
    to_cycle(12);
    chk("pause.step1_held", {bus.aa, bus.bb, bus.cc}, 3'b100);
    chk("pause.idx_held", bus.step_idx, 3'd1);
    tick();
    chk_all("pause.step2", 3'b000, 3'd2, 1'b1, 1'b1, 1'b0);
    to_cycle(40);
    chk_all("pause.pre_done", 3'b110, 3'd6, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("pause.done", 3'b110, 3'd6, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("pause.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

    // abort at E0+18
    launch();
    to_cycle(17);
    chk("abort.pre", {bus.aa, bus.bb, bus.cc}, 3'b110);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_all("abort", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int k = 0; k < 30; k++) begin
        tick();
        seen_done |= bus.done | bus.busy;
      end
      chk("abort.no_done", seen_done, 1'b0);
    end

    // abort and start together in IDLE: start wins
    bus.abort = 1'b1;
    launch();
    bus.abort = 1'b0;
    chk_all("abort_start", 3'b000, 3'd0, 1'b1, 1'b1, 1'b0);
    to_cycle(37);
    chk("abort_start.end", bus.busy, 1'b0);

    // start re-pulsed while busy is ignored
    launch();
    to_cycle(9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart.abc", {bus.aa, bus.bb, bus.cc}, 3'b000);
    chk("restart.idx", bus.step_idx, 3'd2);
    chk("restart.strobe", bus.step_strobe, 1'b0);
    to_cycle(35);
    chk("restart.pre_done", bus.done, 1'b0);
    tick();
    chk_all("restart.done", 3'b110, 3'd6, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("restart.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

    // async reset mid-HOLD, no clock edge in between
    launch();
    to_cycle(30);
    chk("arst.in_hold", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("arst.idle", bus.busy, 1'b0);
    full_run("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
